detect_programmable_sequence_fsm: RTL and testbench
===================================================

Name: detect_programmable_sequence_fsm

Overview:
- Runtime-programmable serial bit-sequence detector; successor to the fixed-pattern FSM detectors.
- Pattern (1..MAX_LEN bits), length and overlap mode are loaded through a valid/ready config port.
- The block builds a DFA transition table, one row per cycle, then detects on a qualified serial input stream.
- Outputs a one-cycle match pulse and a saturating match counter for the status register block.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=1).
- CNT_W, 16: match counter width (>=1).
- LEN_W is derived, not overridable: $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept
- cfg_pattern  in  MAX_LEN  pattern; bit 0 is the first bit received
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- a_valid  in  1  input bit qualifier
- a  in  1  serial input bit
- detected  out  1  registered one-cycle match pulse
- match_count  out  CNT_W  saturating count of matches
- busy  out  1  high while the table build is in progress

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: ctrl state IDLE, match state m=0, table cleared, detected=0, match_count=0, busy=0, cfg_ready=1.
- Top FSM states:
  - IDLE: no valid pattern; cfg_ready=1; a ignored.
  - BUILD: busy=1, cfg_ready=0; a ignored.
  - RUN: cfg_ready=1; detecting.
- Config handshake: transfer occurs on cfg_valid&&cfg_ready. Accepted from IDLE or RUN.
  - Transfer latches pattern, len and overlap, sets m=0, X=0, row j=0, and clears match_count.
  - cfg_len==0 or cfg_len>MAX_LEN: transfer is accepted but the block goes to IDLE.
  - Otherwise the block goes to BUILD.
- BUILD: one row per cycle, j = 0..len-1, exactly cfg_len cycles, then RUN.
  - Row j, for c in {0,1}: delta[j][c] = (c==p[j]) ? j+1 : (j==0 ? 0 : delta[X][c]).
  - Update after row j: X = (j==0) ? 0 : delta[X][p[j]].
  - After the last row, X is latched as restart state R (longest proper border of the pattern).
- RUN, on a_valid=1:
  - n = delta[m][a].
  - If n==len: the match is accepted; detected=1 in the next cycle; match_count+1, saturating at all-ones; m = cfg_overlap ? R : 0.
  - Otherwise m=n.
- RUN, on a_valid=0: m held; detected=0 next cycle.
- detected is high only for the cycle after each accepting sample. Latency from the accepting sample's clock edge to detected high is 1 cycle.
- New config during RUN aborts detection immediately. No detected pulse for the in-flight bit.
- rst mid-BUILD or mid-RUN: return to reset values; the table is invalid until reconfigured.
- Simultaneous cfg transfer and a_valid in RUN: the config wins; the bit is discarded.
- match_count saturates and never wraps.

Decomposition:
- Package detect_seq_pkg holds:
  - the ctrl_state_t enum (IDLE, BUILD, RUN);
  - the LEN_W computation function.
- Sub-module seq_dfa_table_builder:
  - owns the row counter j, X and R, and writes delta rows;
  - exposes start, done, and a read port of delta[m][a] for the detector.
- The top level contains the ctrl FSM, the m register, the detected flop and the counter.

Test Plan:
- Pattern 110011 (cfg_pattern=6'b110011 reversed per bit0-first), len 6, overlap=1, stream 1100110011 → detected after bits 6 and 10; match_count=2; busy high exactly 6 cycles after the config transfer.
- Pattern 1010 (bit0-first), len 4: stream 101010 with overlap=1 → pulses after bits 4 and 6, count=2. Same stream with overlap=0 → pulse after bit 4 only, count=1.
- Pattern 110011, stream 110011 with 3 a_valid=0 idle cycles between every bit → pulse after bit 6 only; the pulse lasts exactly 1 cycle.
- CNT_W=4, pattern "1", len 1, 20 consecutive a=1 valid bits → 20 pulses; match_count saturates at 15.
- cfg_len=0 → IDLE; cfg_len=MAX_LEN+1 → IDLE. In both cases there is no detection on any input.
- rst asserted in BUILD cycle 3 → busy=0 and cfg_ready=1 next cycle; stream 110011 gives no detection until reconfigured.

Source files
------------

// File: rtl/detect_seq_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package detect_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      RUN   = 2'd2
   } ctrl_state_t;

   function automatic int calc_len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_dfa_table_builder.sv
// Builds the KMP-style DFA transition table one row per cycle and serves
// delta[state][bit] lookups to the detector.
module seq_dfa_table_builder
   import detect_seq_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               en,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [LEN_W-1:0]   rd_state,
   input  logic               rd_bit,
   output logic [LEN_W-1:0]   rd_next,
   output logic [LEN_W-1:0]   restart,
   output logic               done
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [LEN_W-1:0] delta_q [MAX_LEN][2];
   logic [LEN_W-1:0] j_q, j_d;
   logic [LEN_W-1:0] x_q, x_d;
   logic [LEN_W-1:0] r_q, r_d;
   logic [IDX_W-1:0] j_idx_s, x_idx_s, rd_idx_s;
   logic             pj_s;
   logic             row_we_s;
   logic [LEN_W-1:0] j_plus1_s, base0_s, base1_s, row0_s, row1_s, x_upd_s;

   // Row j: matching bit advances to j+1, mismatch falls back through the border state X.
   always_comb begin
      j_idx_s   = j_q[IDX_W-1:0];
      x_idx_s   = x_q[IDX_W-1:0];
      rd_idx_s  = rd_state[IDX_W-1:0];
      pj_s      = pattern[j_idx_s];
      j_plus1_s = j_q + LEN_W'(1);
      base0_s   = (j_q == '0) ? '0 : delta_q[x_idx_s][0];
      base1_s   = (j_q == '0) ? '0 : delta_q[x_idx_s][1];
      row0_s    = (pj_s == 1'b0) ? j_plus1_s : base0_s;
      row1_s    = (pj_s == 1'b1) ? j_plus1_s : base1_s;
      x_upd_s   = (j_q == '0) ? '0 : delta_q[x_idx_s][pj_s];

      j_d      = j_q;
      x_d      = x_q;
      r_d      = r_q;
      row_we_s = 1'b0;
      done     = 1'b0;
      if (start) begin
         j_d = '0;
         x_d = '0;
      end else if (en) begin
         row_we_s = 1'b1;
         x_d      = x_upd_s;
         if (j_q == (len - LEN_W'(1))) begin
            done = 1'b1;
            r_d  = x_upd_s;
         end else begin
            j_d = j_plus1_s;
         end
      end else begin
         row_we_s = 1'b0;
      end
   end

   // Table storage, row counter and border registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         j_q <= '0;
         x_q <= '0;
         r_q <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            delta_q[i][0] <= '0;
            delta_q[i][1] <= '0;
         end
      end else begin
         j_q <= j_d;
         x_q <= x_d;
         r_q <= r_d;
         if (row_we_s) begin
            delta_q[j_idx_s][0] <= row0_s;
            delta_q[j_idx_s][1] <= row1_s;
         end
      end
   end

   assign rd_next = delta_q[rd_idx_s][rd_bit];
   assign restart = r_q;

endmodule

// File: rtl/detect_programmable_sequence_fsm.sv
// Runtime-programmable serial sequence detector: config handshake, table build
// control, DFA walk, match pulse and saturating match counter.
module detect_programmable_sequence_fsm
   import detect_seq_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 16,
   localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               a_valid,
   input  logic               a,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               busy
);

   ctrl_state_t        state_q, state_d;
   logic [LEN_W-1:0]   m_q, m_d;
   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic               detected_q, detected_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               busy_q, busy_d;
   logic               cfg_ready_q, cfg_ready_d;

   logic               cfg_xfer_s, len_ok_s, build_start_s, build_en_s, build_done_s;
   logic [LEN_W-1:0]   next_s, restart_s;

   seq_dfa_table_builder #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_builder (
      .clk      (clk),
      .rst      (rst),
      .start    (build_start_s),
      .en       (build_en_s),
      .pattern  (pattern_q),
      .len      (len_q),
      .rd_state (m_q),
      .rd_bit   (a),
      .rd_next  (next_s),
      .restart  (restart_s),
      .done     (build_done_s)
   );

   assign build_en_s = (state_q == BUILD);

   // Control FSM next state, DFA step and counter update; a config transfer pre-empts the input bit.
   always_comb begin
      cfg_xfer_s    = cfg_valid && cfg_ready_q;
      len_ok_s      = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
      state_d       = state_q;
      m_d           = m_q;
      pattern_d     = pattern_q;
      len_d         = len_q;
      overlap_d     = overlap_q;
      detected_d    = 1'b0;
      count_d       = count_q;
      build_start_s = 1'b0;

      if (cfg_xfer_s) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         m_d       = '0;
         count_d   = '0;
         if (len_ok_s) begin
            state_d       = BUILD;
            build_start_s = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            BUILD: begin
               if (build_done_s) begin
                  state_d = RUN;
               end else begin
                  state_d = BUILD;
               end
            end
            RUN: begin
               if (a_valid) begin
                  if (next_s == len_q) begin
                     detected_d = 1'b1;
                     m_d        = overlap_q ? restart_s : '0;
                     if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                     end else begin
                        count_d = count_q;
                     end
                  end else begin
                     m_d = next_s;
                  end
               end else begin
                  m_d = m_q;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d      = (state_d == BUILD);
      cfg_ready_d = (state_d != BUILD);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         m_q         <= '0;
         pattern_q   <= '0;
         len_q       <= '0;
         overlap_q   <= 1'b0;
         detected_q  <= 1'b0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         pattern_q   <= pattern_d;
         len_q       <= len_d;
         overlap_q   <= overlap_d;
         detected_q  <= detected_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign detected    = detected_q;
   assign match_count = count_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_detect_programmable_sequence_fsm.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor checks them.
module tb_detect_programmable_sequence_fsm;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 4;
   localparam int LEN_W   = 4;
   localparam int CNT_MAX = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               a_valid;
   logic               a;
   logic               detected;
   logic [CNT_W-1:0]   match_count;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_edge_q[$];
   int exp_cnt_q[$];

   detect_programmable_sequence_fsm #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .a_valid     (a_valid),
      .a           (a),
      .detected    (detected),
      .match_count (match_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse must match the head of the expected queue, in cycle and count.
   always @(negedge clk) begin
      int dummy;
      if (exp_edge_q.size() > 0 && exp_edge_q[0] == cyc) begin
         n_checks++;
         if (detected !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_missing: edge %0d detected=%0b required 1", cyc, detected);
         end else if (match_count !== CNT_W'(exp_cnt_q[0])) begin
            n_fail++;
            $display("FAIL pulse_count: edge %0d match_count=%0d required %0d",
                     cyc, match_count, exp_cnt_q[0]);
         end
         dummy = exp_edge_q.pop_front();
         dummy = exp_cnt_q.pop_front();
      end else if (detected !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_pulse: edge %0d detected=%0b required 0", cyc, detected);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ovl, input int exp_busy, input logic with_bit,
                            input string name);
      int k;
      check({name, "_ready"}, 32'(cfg_ready), 32'd1);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      cfg_valid   = 1'b1;
      a_valid     = with_bit;
      a           = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      a_valid   = 1'b0;
      k = 0;
      while (busy === 1'b1 && k < 20) begin
         k++;
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, 32'(k), 32'(exp_busy));
      check({name, "_count_clr"}, 32'(match_count), 32'd0);
      check({name, "_ready_after"}, 32'(cfg_ready), 32'd1);
   endtask

   task automatic run_stream(input logic [31:0] bits, input int n, input logic [31:0] mask,
                             input int gap, input int cnt0, input string name);
      int cnt = cnt0;
      for (int i = 0; i < n; i++) begin
         a_valid = 1'b1;
         a       = bits[i];
         if (mask[i]) begin
            if (cnt < CNT_MAX) cnt++;
            exp_edge_q.push_back(cyc + 1);
            exp_cnt_q.push_back(cnt);
         end
         @(negedge clk);
         a_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      check({name, "_count"}, 32'(match_count), 32'(cnt));
      check({name, "_drained"}, 32'(exp_edge_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      cfg_valid   = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      a_valid     = 1'b0;
      a           = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_detected", 32'(detected), 32'd0);
      check("rst_count", 32'(match_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // 110011, overlapping: hits after bits 6 and 10.
      configure(8'h33, 4'd6, 1'b1, 6, 1'b0, "p110011");
      run_stream(32'h333, 10, 32'h220, 0, 0, "p110011_s1");

      // 1010 with and without overlap.
      configure(8'h05, 4'd4, 1'b1, 4, 1'b0, "p1010_ov");
      run_stream(32'h15, 6, 32'h28, 0, 0, "p1010_ov_s");
      configure(8'h05, 4'd4, 1'b0, 4, 1'b0, "p1010_no");
      run_stream(32'h15, 6, 32'h08, 0, 0, "p1010_no_s");

      // Gapped stream: held state across idle cycles, single-cycle pulse.
      configure(8'h33, 4'd6, 1'b1, 6, 1'b0, "gap");
      run_stream(32'h33, 6, 32'h20, 3, 0, "gap_s");

      // Single-bit pattern, counter saturates at 15.
      configure(8'h01, 4'd1, 1'b1, 1, 1'b0, "sat");
      run_stream(32'hFFFFF, 20, 32'hFFFFF, 0, 0, "sat_s");

      // Illegal lengths leave the block idle.
      configure(8'h33, 4'd0, 1'b1, 0, 1'b0, "len0");
      run_stream(32'h33, 6, 32'h0, 0, 0, "len0_s");
      configure(8'h33, 4'd9, 1'b1, 0, 1'b0, "len9");
      run_stream(32'h33, 6, 32'h0, 0, 0, "len9_s");

      // Config arriving with the completing bit wins; the bit is dropped.
      configure(8'h33, 4'd6, 1'b1, 6, 1'b0, "abort");
      run_stream(32'h13, 5, 32'h0, 0, 0, "abort_pre");
      configure(8'h33, 4'd6, 1'b1, 6, 1'b1, "abort_cfg");
      run_stream(32'h33, 6, 32'h20, 0, 0, "abort_post");

      // Reset during BUILD cycle 3.
      cfg_pattern = 8'h33;
      cfg_len     = 4'd6;
      cfg_overlap = 1'b1;
      cfg_valid   = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstb_busy", 32'(busy), 32'd0);
      check("rstb_ready", 32'(cfg_ready), 32'd1);
      check("rstb_count", 32'(match_count), 32'd0);
      run_stream(32'h33, 6, 32'h0, 0, 0, "rstb_s");
      configure(8'h33, 4'd6, 1'b1, 6, 1'b0, "rstb_recfg");
      run_stream(32'h33, 6, 32'h20, 0, 0, "rstb_recfg_s");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
